softreg_router: RTL
===================

Name: softreg_router

Overview:
- Shares the single shell soft-register channel among NUM_SLAVES CSR blocks: engine CSR, SL3 statistics, PCIe receiver statistics, and others.
- Decodes the address into a per-slave window and forwards writes fire-and-forget.
- Sequences reads with one outstanding read, a timeout, and an ordered return path.
- Sits between the shell soft-register port and all engine CSR instances.

Parameters:
- NUM_SLAVES, 4, number of CSR slaves.
- BASE_ADDR, 200, first address of slave 0's window.
- WINDOW, 32, addresses per slave. Slave i owns [BASE_ADDR+i*WINDOW, BASE_ADDR+(i+1)*WINDOW).
- TIMEOUT_CYCLES, 64, cycles to wait for a slave read response.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- host_req  in  SoftRegReq  shell request {valid, isWrite, addr, data[63:0]}
- host_resp  out  SoftRegResp  response to shell {valid, data[63:0]}
- slv_req[NUM_SLAVES]  out  SoftRegReq  per-slave request; address passed unmodified
- slv_resp[NUM_SLAVES]  in  SoftRegResp  per-slave response
- busy  out  1  read outstanding
- num_timeouts  out  32  reads that timed out
- num_decode_errs  out  32  accesses outside every window
- num_dropped  out  32  requests lost because the skid buffer was full
- num_stray_resps  out  32  responses not matching the outstanding read

Behaviour:
- Reset: all slv_req.valid=0, host_resp.valid=0, host_resp.data=0, busy=0, all counters=0, FSM=IDLE, skid empty.
- Decode:
  - idx = (addr-BASE_ADDR)/WINDOW, computed combinationally.
  - hit = addr>=BASE_ADDR && idx<NUM_SLAVES.
  - addr<BASE_ADDR is a miss; no underflow wrap.
- Request register: the host request is registered once. The forwarded slv_req[idx] is valid exactly 1 cycle after acceptance, carrying identical isWrite/addr/data. All other slaves see valid=0 that cycle.
- FSM IDLE:
  - Write hit: forward and stay IDLE. Back-to-back writes are sustained 1 per cycle.
  - Write miss: dropped; num_decode_errs++.
  - Read hit: forward, latch idx into tgt, load timer=TIMEOUT_CYCLES-1, go WAIT; busy=1.
  - Read miss: host_resp valid 2 cycles after the request, data=64'hFFFF_FFFF_FFFF_FFFF; num_decode_errs++; stay IDLE.
- FSM WAIT:
  - slv_resp[tgt].valid: host_resp.valid=1 next cycle with that data; go IDLE; busy=0.
  - Timer reaches 0 with no response: host_resp.valid=1 next cycle, data=64'hDEAD_DEAD_DEAD_DEAD; num_timeouts++; go IDLE.
  - Response and timer expiry in the same cycle: the response wins; no timeout is counted.
- Response filtering: any slv_resp[j].valid with j!=tgt, or any response while IDLE (e.g. late after a timeout), is discarded and num_stray_resps++. Several strays in one cycle count as 1 per cycle (saturating counters are not required; wrap at 2^32).
- Skid buffer: 1 entry. A host request arriving in WAIT is stored in the skid. A request arriving while the skid is full is discarded; num_dropped++.
- Leaving WAIT:
  - The skid entry is processed as a fresh IDLE request on the IDLE cycle.
  - That IDLE cycle ignores host_req arriving simultaneously: the host request goes into the skid if it is empty, else it is dropped.
  - Ordering is strictly preserved.
- Output timing: host_resp.valid is a single-cycle pulse; host_resp.data holds its value otherwise.
- Reset mid-read: the FSM returns to IDLE; no response is issued; the pending skid entry is lost.

Decomposition:
- Shared package DTEngine_Types gets SOFTREG_TIMEOUT_DATA (64'hDEAD_DEAD_DEAD_DEAD) and SOFTREG_MISS_DATA (all ones).
- Package also gets a typedef softreg_state_t {SR_IDLE, SR_WAIT}.
- One natural sub-module: softreg_decode (combinational addr -> {hit, idx}), reused by future CSR blocks.

Test Plan:
- Reset defaults: after reset release, all outputs are 0 and busy=0. Write addr 205, data 0x1234: slv_req[0] valid 1 cycle later, addr 205, data 0x1234; other slaves idle.
- Read routing: read addr 234 -> slv_req[1] valid, busy=1. slv_resp[1] returns 0xABCD after 5 cycles -> host_resp valid 1 cycle later, data 0xABCD; busy=0.
- Timeout: read addr 270 with slave 2 silent -> host_resp data 0xDEADDEADDEADDEAD at cycle TIMEOUT_CYCLES+2; num_timeouts=1. Slave 2 answering afterwards -> num_stray_resps=1.
- Decode errors:
  - Read addr 199 -> host_resp all ones 2 cycles later; num_decode_errs=1.
  - Write addr 328 (NUM_SLAVES=4) -> no slv_req valid; num_decode_errs=2.
- Skid and drop:
  - During WAIT, issue write 210 then write 211. 210 is forwarded after the read completes; 211 is dropped; num_dropped=1.
  - Response and timer expiry coinciding -> response data is returned; num_timeouts unchanged.

Source files
------------

// File: rtl/DTEngine_Types.sv
// Shared engine types: shell soft-register bundles and router constants.
// Imported by every CSR-facing block.
package DTEngine_Types;

  localparam int SR_AW = 32;

  localparam logic [63:0] SOFTREG_TIMEOUT_DATA = 64'hDEAD_DEAD_DEAD_DEAD;
  localparam logic [63:0] SOFTREG_MISS_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic             valid;
    logic             isWrite;
    logic [SR_AW-1:0] addr;
    logic [63:0]      data;
  } SoftRegReq;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } SoftRegResp;

  typedef enum logic {
    SR_IDLE,
    SR_WAIT
  } softreg_state_t;

endpackage

// File: rtl/softreg_decode.sv
// Soft-register window decoder: address -> {hit, slave index}.
// Addresses below the base are a miss rather than wrapping.
module softreg_decode
  import DTEngine_Types::*;
#(
  parameter int AW         = SR_AW,
  parameter int NUM_SLAVES = 4,
  parameter int BASE_ADDR  = 200,
  parameter int WINDOW     = 32,
  parameter int IW         = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic [IW-1:0] idx
);

  logic [AW-1:0] off;
  logic [AW-1:0] q;

  always_comb begin
    off = addr - AW'(BASE_ADDR);
    q   = off / AW'(WINDOW);
    hit = (addr >= AW'(BASE_ADDR)) && (q < AW'(NUM_SLAVES));
    idx = q[IW-1:0];
  end

endmodule

// File: rtl/softreg_router.sv
// Shares the shell soft-register channel among several CSR slaves.
// One read in flight with timeout; a 1-entry skid keeps requests ordered.
module softreg_router
  import DTEngine_Types::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int BASE_ADDR      = 200,
  parameter int WINDOW         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  SoftRegReq   host_req,
  output SoftRegResp  host_resp,
  output SoftRegReq   slv_req [NUM_SLAVES],
  input  SoftRegResp  slv_resp [NUM_SLAVES],
  output logic        busy,
  output logic [31:0] num_timeouts,
  output logic [31:0] num_decode_errs,
  output logic [31:0] num_dropped,
  output logic [31:0] num_stray_resps
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  softreg_state_t state, state_nx;
  SoftRegReq      req_q, skid_q, skid_nx, cur;
  SoftRegResp     resp_nx;
  logic [IW-1:0]  tgt, tgt_nx, idx;
  logic [TW-1:0]  timer, timer_nx;
  logic           hit, fwd, stray;
  logic           to_inc, de_inc, drop_inc;

  // A held skid entry is older than the registered host request.
  assign cur  = skid_q.valid ? skid_q : req_q;
  assign fwd  = (state == SR_IDLE) && cur.valid && hit;
  assign busy = (state == SR_WAIT);

  softreg_decode #(
    .AW        (SR_AW),
    .NUM_SLAVES(NUM_SLAVES),
    .BASE_ADDR (BASE_ADDR),
    .WINDOW    (WINDOW),
    .IW        (IW)
  ) u_dec (
    .addr(cur.addr),
    .hit (hit),
    .idx (idx)
  );

  always_comb begin
    stray = 1'b0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      slv_req[j]       = cur;
      slv_req[j].valid = fwd && (idx == IW'(j));
      if (slv_resp[j].valid &&
          (state == SR_IDLE || tgt != IW'(j)))
        stray = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    skid_nx  = skid_q;
    tgt_nx   = tgt;
    timer_nx = timer;
    resp_nx  = '{valid: 1'b0, data: host_resp.data};
    to_inc   = 1'b0;
    de_inc   = 1'b0;
    drop_inc = 1'b0;
    unique case (state)
      SR_IDLE: begin
        skid_nx = skid_q.valid ? req_q : '0;
        if (cur.valid) begin
          if (!hit) begin
            de_inc = 1'b1;
            if (!cur.isWrite)
              resp_nx = '{valid: 1'b1, data: SOFTREG_MISS_DATA};
          end else if (!cur.isWrite) begin
            state_nx = SR_WAIT;
            tgt_nx   = idx;
            timer_nx = TW'(TIMEOUT_CYCLES - 1);
          end
        end
      end
      SR_WAIT: begin
        if (req_q.valid) begin
          if (skid_q.valid) drop_inc = 1'b1;
          else              skid_nx  = req_q;
        end
        if (slv_resp[tgt].valid) begin
          resp_nx  = '{valid: 1'b1, data: slv_resp[tgt].data};
          state_nx = SR_IDLE;
        end else if (timer == '0) begin
          resp_nx  = '{valid: 1'b1, data: SOFTREG_TIMEOUT_DATA};
          to_inc   = 1'b1;
          state_nx = SR_IDLE;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= SR_IDLE;
      req_q           <= '0;
      skid_q          <= '0;
      tgt             <= '0;
      timer           <= '0;
      host_resp       <= '0;
      num_timeouts    <= '0;
      num_decode_errs <= '0;
      num_dropped     <= '0;
      num_stray_resps <= '0;
    end else begin
      state           <= state_nx;
      req_q           <= host_req;
      skid_q          <= skid_nx;
      tgt             <= tgt_nx;
      timer           <= timer_nx;
      host_resp       <= resp_nx;
      num_timeouts    <= num_timeouts + {31'd0, to_inc};
      num_decode_errs <= num_decode_errs + {31'd0, de_inc};
      num_dropped     <= num_dropped + {31'd0, drop_inc};
      num_stray_resps <= num_stray_resps + {31'd0, stray};
    end
  end

endmodule
